// File: rtl/avg_filter_pkg.sv
// Shared types and defaults for the moving-average FIR sequencer.
//   state_e   : controller states
//   DEPTH_DEF : default window length in samples
//   CNT_W_DEF : default occupancy counter width
package avg_filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DRAIN,
        ST_CLEAR
    } state_e;

    localparam int DEPTH_DEF = 16;
    localparam int CNT_W_DEF = 5;

endpackage

// File: rtl/avg_filter_ctrl_window_counter.sv
// Up/down FIFO occupancy counter for the averaging window.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   inc_i, dec_i  : count one up / one down (never both at once)
//   count_o       : current occupancy, saturates at 0 and DEPTH
//   is_zero_o     : occupancy == 0
//   is_full_m1_o  : occupancy == DEPTH-1 (next write completes the window)
module window_counter #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             is_zero_o,
    output logic             is_full_m1_o
);

    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DEPTH - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && count_q != FULL) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o      = count_q;
    assign is_zero_o    = (count_q == '0);
    assign is_full_m1_o = (count_q == FULL_M1);

endmodule

// File: rtl/avg_filter_ctrl.sv
// Sequencer for the moving-average FIR. Fills the delay line to DEPTH
// samples, then runs one-in/one-out; a flush drains the window and pulses
// an accumulator clear before refilling.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   sample_valid_i : new sample on the filter input this cycle
//   flush_i        : discard window and restart fill
//   write_o/read_o : FIFO strobes (combinational)
//   acc_clr_o      : registered accumulator clear pulse (held in reset)
//   out_valid_o    : registered, filter output is a full-window average
//   fill_cnt_o     : registered FIFO occupancy
//   drop_o         : registered pulse, a sample was discarded
module avg_filter_ctrl
    import avg_filter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_valid_i,
    input  logic             flush_i,
    output logic             write_o,
    output logic             read_o,
    output logic             acc_clr_o,
    output logic             out_valid_o,
    output logic [CNT_W-1:0] fill_cnt_o,
    output logic             drop_o
);

    state_e           state_q, state_d;
    logic             acc_clr_q, out_valid_q, drop_q;
    logic             out_valid_d, drop_d;
    logic             active;   // FILL or RUN: states that take samples and honour FLUSH
    logic             take;     // sample accepted this cycle
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero, cnt_full_m1;

    window_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inc_i        (write_o & ~read_o),
        .dec_i        (read_o & ~write_o),
        .count_o      (cnt),
        .is_zero_o    (cnt_zero),
        .is_full_m1_o (cnt_full_m1)
    );

    always_comb begin
        active      = (state_q == ST_FILL) || (state_q == ST_RUN);
        take        = sample_valid_i && active && !flush_i;
        write_o     = take;
        // RUN reads alongside each write; DRAIN reads until the FIFO is empty
        read_o      = (take && state_q == ST_RUN) || (state_q == ST_DRAIN && !cnt_zero);
        drop_d      = sample_valid_i && !take;
        out_valid_d = out_valid_q;
        if (active && flush_i)              out_valid_d = 1'b0;
        else if (take && state_q == ST_RUN) out_valid_d = 1'b1;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FILL;
            ST_FILL:  if (flush_i)                  state_d = ST_DRAIN;
                      else if (take && cnt_full_m1) state_d = ST_RUN;
            ST_RUN:   if (flush_i)                  state_d = ST_DRAIN;
            // last read (count 1) or entered empty both go straight to CLEAR
            ST_DRAIN: if (cnt_zero || cnt == CNT_W'(1)) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_FILL;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            acc_clr_q   <= 1'b1;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_clr_q   <= (state_d == ST_CLEAR);
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign acc_clr_o   = acc_clr_q;
    assign out_valid_o = out_valid_q;
    assign drop_o      = drop_q;
    assign fill_cnt_o  = cnt;

endmodule

// File: tb/tb_avg_filter_ctrl.sv
module tb_avg_filter_ctrl;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    // reference model phases
    localparam int P_IDLE  = 0;
    localparam int P_FILL  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_CLEAR = 4;

    logic             clk = 1'b0;
    logic             rst, sv, fl;
    logic             write_o, read_o, acc_clr_o, out_valid_o, drop_o;
    logic [CNT_W-1:0] fill_cnt_o;

    always #5 clk = ~clk;

    avg_filter_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sample_valid_i (sv),
        .flush_i        (fl),
        .write_o        (write_o),
        .read_o         (read_o),
        .acc_clr_o      (acc_clr_o),
        .out_valid_o    (out_valid_o),
        .fill_cnt_o     (fill_cnt_o),
        .drop_o         (drop_o)
    );

    int errs = 0, checks = 0;
    int ph = P_IDLE, occ = 0;
    bit m_acc = 1'b1, m_ov = 1'b0, m_drop = 1'b0;
    bit en = 1'b0;
    int n_wr = 0, n_rd = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check against the model, advance the model.
    task automatic cyc(input bit r, input bit s, input bit f);
        bit acc_ok, e_w, e_r;
        int nocc;
        rst = r; sv = s; fl = f;
        #3;
        acc_ok = (ph == P_FILL || ph == P_RUN) && !f;
        e_w    = s && acc_ok;
        e_r    = (ph == P_RUN && e_w) || (ph == P_DRAIN && occ > 0);
        if (en) begin
            chk("write",     32'(write_o),     32'(e_w));
            chk("read",      32'(read_o),      32'(e_r));
            chk("acc_clr",   32'(acc_clr_o),   32'(m_acc));
            chk("out_valid", 32'(out_valid_o), 32'(m_ov));
            chk("drop",      32'(drop_o),      32'(m_drop));
            chk("fill_cnt",  32'(fill_cnt_o),  32'(occ));
        end
        n_wr += int'(write_o);
        n_rd += int'(read_o);
        @(posedge clk);
        if (r) begin
            ph = P_IDLE; occ = 0; m_ov = 1'b0; m_drop = 1'b0; m_acc = 1'b1;
        end else begin
            m_drop = s && !acc_ok;
            if ((ph == P_FILL || ph == P_RUN) && f) m_ov = 1'b0;
            else if (ph == P_RUN && s)             m_ov = 1'b1;
            nocc = occ + int'(e_w) - int'(e_r);
            case (ph)
                P_IDLE:  ph = P_FILL;
                P_FILL:  if (f) ph = P_DRAIN;
                         else if (e_w && nocc == DEPTH) ph = P_RUN;
                P_RUN:   if (f) ph = P_DRAIN;
                P_DRAIN: if (nocc == 0) ph = P_CLEAR;
                default: ph = P_FILL;
            endcase
            occ   = nocc;
            m_acc = (ph == P_CLEAR);
        end
        en = 1'b1;
        #1;
    endtask

    task automatic fill_to(input int target);
        int g = 0;
        while (occ < target && g < 400) begin
            cyc(0, 1'($urandom_range(0, 1)), 0);
            g++;
        end
        chk("fill_timeout", 32'(g < 400), 32'd1);
    endtask

    // run until the accumulator-clear pulse; s_mode 2 = random samples
    task automatic drain(input int s_mode, input int exp_reads);
        int g = 0;
        n_rd = 0; n_wr = 0;
        while (acc_clr_o !== 1'b1 && g < 60) begin
            cyc(0, (s_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(s_mode), 0);
            g++;
        end
        chk("drain_timeout", 32'(g < 60), 32'd1);
        chk("drain_reads",   32'(n_rd), 32'(exp_reads));
        chk("drain_writes",  32'(n_wr), 32'd0);
        cyc(0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; sv = 1'b0; fl = 1'b0;
        @(posedge clk); #1;

        // reset for 3 cycles, then the idle cycle
        repeat (3) cyc(1, 0, 0);
        chk("rst_acc_clr", 32'(acc_clr_o), 32'd1);
        cyc(0, 0, 0);
        chk("post_rst_acc_clr", 32'(acc_clr_o), 32'd0);
        chk("post_rst_cnt",     32'(fill_cnt_o), 32'd0);

        // fill window, then first RUN sample
        n_wr = 0; n_rd = 0;
        fill_to(DEPTH);
        chk("fill_writes", 32'(n_wr), 32'(DEPTH));
        chk("fill_reads",  32'(n_rd), 32'd0);
        chk("full_cnt",    32'(fill_cnt_o), 32'(DEPTH));
        chk("ov_before_run", 32'(out_valid_o), 32'd0);
        cyc(0, 1, 0);
        chk("ov_after_run", 32'(out_valid_o), 32'd1);
        repeat (10) cyc(0, 1'($urandom_range(0, 1)), 0);

        // flush in RUN: full drain then clear
        cyc(0, 0, 1);
        chk("ov_after_flush", 32'(out_valid_o), 32'd0);
        drain(2, DEPTH);

        // flush colliding with a sample at count 5, samples every drain cycle
        fill_to(5);
        cyc(0, 1, 1);
        chk("flush_drop", 32'(drop_o), 32'd1);
        drain(1, 5);

        // flush on an empty window goes straight to clear
        cyc(0, 0, 1);
        drain(0, 0);

        // reset in RUN
        fill_to(DEPTH);
        repeat (3) cyc(0, 1, 0);
        cyc(1, 1, 0);
        chk("rst_run_ov",  32'(out_valid_o), 32'd0);
        chk("rst_run_cnt", 32'(fill_cnt_o),  32'd0);
        cyc(0, 0, 0);

        // random traffic
        repeat (600) begin
            cyc(($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
